// File: rtl/circle_pixel_shader.sv
// circle_pixel_shader
//   Per-pixel circle hit tester. Holds a double-buffered table of N_CIRCLES
//   circles (shadow written by the loader, active used for shading). Each
//   streamed pixel is tested against every enabled active circle. The colour
//   of the lowest-indexed hit, or bg_color, is produced 4 cycles later.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   wr_en/wr_idx        write one shadow entry (out-of-range index ignored)
//   wr_circle           {x, y, r}, each signed 12-bit
//   wr_color            {r, g, b}, 4 bits each
//   commit              request shadow->active copy at next frame_start pixel
//   commit_pending      a commit is latched but not yet applied
//   bg_color            background colour, sampled in the last stage
//   px_valid/px_x/px_y  input pixel coordinate (signed 12-bit)
//   frame_start         first pixel of a frame, qualified by px_valid
//   pix_valid/pix_color shaded result, px_valid delayed by 4
module circle_pixel_shader #(
  parameter int N_CIRCLES = 8,
  parameter int IDX_W     = $clog2(N_CIRCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [35:0]      wr_circle,
  input  logic [11:0]      wr_color,
  input  logic             commit,
  output logic             commit_pending,
  input  logic [11:0]      bg_color,
  input  logic             px_valid,
  input  logic [11:0]      px_x,
  input  logic [11:0]      px_y,
  input  logic             frame_start,
  output logic             pix_valid,
  output logic [11:0]      pix_color
);

  localparam int unsigned NC = N_CIRCLES;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state, state_nx;
  logic   swap;

  // Tables
  logic [11:0]    sh_x [NC];
  logic [11:0]    sh_y [NC];
  logic [11:0]    sh_r [NC];
  logic [11:0]    sh_col [NC];
  logic [NC-1:0]  sh_en;
  logic [11:0]    act_x [NC];
  logic [11:0]    act_y [NC];
  logic [11:0]    act_r [NC];
  logic [11:0]    act_col [NC];
  logic [NC-1:0]  act_en;

  // Shadow contents including this cycle's write
  logic [11:0]    nx_x [NC];
  logic [11:0]    nx_y [NC];
  logic [11:0]    nx_r [NC];
  logic [11:0]    nx_col [NC];
  logic [NC-1:0]  nx_en;

  // Table seen by the pixel entering S1 (new table on the swap cycle)
  logic [11:0]    ev_x [NC];
  logic [11:0]    ev_y [NC];
  logic [11:0]    ev_r [NC];
  logic [11:0]    ev_col [NC];
  logic [NC-1:0]  ev_en;
  logic [23:0]    r_ext [NC];

  // Pipeline
  logic           v1, v2, v3;
  logic [12:0]    dx1 [NC];
  logic [12:0]    dy1 [NC];
  logic [23:0]    r2_1 [NC];
  logic [NC-1:0]  live1;
  logic [11:0]    col1 [NC];
  logic [24:0]    dx_ext [NC];
  logic [24:0]    dy_ext [NC];
  logic [24:0]    dxsq2 [NC];
  logic [24:0]    dysq2 [NC];
  logic [23:0]    r2_2 [NC];
  logic [NC-1:0]  live2;
  logic [11:0]    col2 [NC];
  logic [NC-1:0]  hit3;
  logic [11:0]    col3 [NC];
  logic [11:0]    sel_col;

  // ---------------------------------------------------------------- commit FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    swap     = 1'b0;
    case (state)
      IDLE:    if (commit) state_nx = PENDING;
      PENDING: if (px_valid && frame_start) begin
        swap     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign commit_pending = (state == PENDING);

  // ---------------------------------------------------------------- tables
  // The write is merged ahead of the copy so a write in the swap cycle lands
  // in both shadow and active.
  always_comb begin
    nx_en = sh_en;
    for (int unsigned i = 0; i < NC; i++) begin
      nx_x[i]   = sh_x[i];
      nx_y[i]   = sh_y[i];
      nx_r[i]   = sh_r[i];
      nx_col[i] = sh_col[i];
      if (wr_en && (32'(wr_idx) == i)) begin
        nx_x[i]   = wr_circle[35:24];
        nx_y[i]   = wr_circle[23:12];
        nx_r[i]   = wr_circle[11:0];
        nx_col[i] = wr_color;
        nx_en[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NC; i++) begin
      sh_x[i]   <= nx_x[i];
      sh_y[i]   <= nx_y[i];
      sh_r[i]   <= nx_r[i];
      sh_col[i] <= nx_col[i];
      if (swap) begin
        act_x[i]   <= nx_x[i];
        act_y[i]   <= nx_y[i];
        act_r[i]   <= nx_r[i];
        act_col[i] <= nx_col[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_en  <= '0;
      act_en <= '0;
    end else begin
      sh_en <= nx_en;
      if (swap) act_en <= nx_en;
    end
  end

  always_comb begin
    ev_en = swap ? nx_en : act_en;
    for (int unsigned i = 0; i < NC; i++) begin
      ev_x[i]   = swap ? nx_x[i]   : act_x[i];
      ev_y[i]   = swap ? nx_y[i]   : act_y[i];
      ev_r[i]   = swap ? nx_r[i]   : act_r[i];
      ev_col[i] = swap ? nx_col[i] : act_col[i];
      r_ext[i]  = {{12{ev_r[i][11]}}, ev_r[i]};
    end
  end

  // ---------------------------------------------------------------- pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= px_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Squares are taken on sign-extended operands; the true results fit in the
  // target widths, so the low bits are exact.
  always_comb begin
    for (int unsigned i = 0; i < NC; i++) begin
      dx_ext[i] = {{12{dx1[i][12]}}, dx1[i]};
      dy_ext[i] = {{12{dy1[i][12]}}, dy1[i]};
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NC; i++) begin
      // S1
      dx1[i]   <= {px_x[11], px_x} - {ev_x[i][11], ev_x[i]};
      dy1[i]   <= {px_y[11], px_y} - {ev_y[i][11], ev_y[i]};
      r2_1[i]  <= r_ext[i] * r_ext[i];
      live1[i] <= ev_en[i] && !ev_r[i][11] && (ev_r[i] != '0);
      col1[i]  <= ev_col[i];
      // S2
      dxsq2[i] <= dx_ext[i] * dx_ext[i];
      dysq2[i] <= dy_ext[i] * dy_ext[i];
      r2_2[i]  <= r2_1[i];
      live2[i] <= live1[i];
      col2[i]  <= col1[i];
      // S3
      hit3[i]  <= live2[i] &&
                  (({1'b0, dxsq2[i]} + {1'b0, dysq2[i]}) <= {2'b00, r2_2[i]});
      col3[i]  <= col2[i];
    end
  end

  // S4: scan from the top so the lowest hit index is the last to assign.
  always_comb begin
    sel_col = bg_color;
    for (int unsigned i = NC; i > 0; i--) begin
      if (hit3[i-1]) sel_col = col3[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_color <= '0;
    end else begin
      pix_valid <= v3;
      if (v3) pix_color <= sel_col;
    end
  end

endmodule

// File: tb/tb_circle_pixel_shader.sv
// Self-checking bench for circle_pixel_shader: directed pixel tables with
// hand-computed colours, commit-timing and reset sequences, and a random
// bubble stream checked against a behavioural circle model.
module tb_circle_pixel_shader;

  localparam int N = 8;
  localparam logic [11:0] BG = 12'h00F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [35:0] wr_circle;
  logic [11:0] wr_color;
  logic        commit;
  logic        commit_pending;
  logic [11:0] bg_color;
  logic        px_valid;
  logic [11:0] px_x, px_y;
  logic        frame_start;
  logic        pix_valid;
  logic [11:0] pix_color;

  circle_pixel_shader #(.N_CIRCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_circle(wr_circle), .wr_color(wr_color), .commit(commit),
    .commit_pending(commit_pending), .bg_color(bg_color),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [11:0] last_col;

  // Behavioural tables for the streaming check
  int   m_sh_x [N], m_sh_y [N], m_sh_r [N];
  logic [11:0] m_sh_c [N];
  logic m_sh_en [N];
  int   m_x [N], m_y [N], m_r [N];
  logic [11:0] m_c [N];
  logic m_en [N];

  typedef struct {
    int x;
    int y;
    logic fs;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input int x, input int y);
    int dx, dy;
    for (int i = 0; i < N; i++) begin
      dx = x - m_x[i];
      dy = y - m_y[i];
      if (m_en[i] && m_r[i] > 0 && (dx * dx + dy * dy) <= m_r[i] * m_r[i])
        return m_c[i];
    end
    return BG;
  endfunction

  task automatic model_swap();
    for (int i = 0; i < N; i++) begin
      m_x[i] = m_sh_x[i]; m_y[i] = m_sh_y[i]; m_r[i] = m_sh_r[i];
      m_c[i] = m_sh_c[i]; m_en[i] = m_sh_en[i];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sh_en[i] = 1'b0;
      m_en[i] = 1'b0;
    end
  endtask

  // Sets write signals without advancing time.
  task automatic set_wr(input int idx, input int x, input int y, input int r, input logic [11:0] col);
    wr_en = 1'b1;
    wr_idx = 3'(idx);
    wr_circle = {12'(x), 12'(y), 12'(r)};
    wr_color = col;
    m_sh_x[idx] = x; m_sh_y[idx] = y; m_sh_r[idx] = r;
    m_sh_c[idx] = col; m_sh_en[idx] = 1'b1;
  endtask

  task automatic write_entry(input int idx, input int x, input int y, input int r, input logic [11:0] col);
    set_wr(idx, x, y, r, col);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    check("commit_latch", 12'(commit_pending), 12'h1);
  endtask

  // One pixel, then the pipeline is observed until its result appears.
  task automatic apply_px(input int x, input int y, input logic fs, input logic cm,
                          input logic [11:0] exp, input logic cp, input string name);
    px_valid = 1'b1; px_x = 12'(x); px_y = 12'(y);
    frame_start = fs; commit = cm;
    @(negedge clk);
    px_valid = 1'b0; frame_start = 1'b0; commit = 1'b0; wr_en = 1'b0;
    check({name, " pending"}, 12'(commit_pending), 12'(cp));
    @(negedge clk);
    @(negedge clk);
    check({name, " early_valid"}, 12'(pix_valid), 12'h0);
    check({name, " hold"}, pix_color, last_col);
    @(negedge clk);
    check({name, " valid"}, 12'(pix_valid), 12'h1);
    check({name, " color"}, pix_color, exp);
    last_col = exp;
  endtask

  task automatic add(input int x, input int y, input logic fs, input logic [11:0] exp);
    vec_t v;
    v.x = x; v.y = y; v.fs = fs; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string grp);
    for (int i = 0; i < tbl.size(); i++)
      apply_px(tbl[i].x, tbl[i].y, tbl[i].fs, 1'b0, tbl[i].exp, 1'b0,
               $sformatf("%s[%0d]", grp, i));
    tbl.delete();
  endtask

  function automatic int rnd_coord();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 4095)) - 2048;
    return int'($urandom_range(0, 300)) - 150;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] q[$];
    logic [12:0] e;
    logic v;
    int x, y;

    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_circle = '0; wr_color = '0;
    commit = 1'b0; bg_color = BG; px_valid = 1'b0; px_x = '0; px_y = '0;
    frame_start = 1'b0;
    model_clear();
    last_col = 12'h000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst pix_valid", 12'(pix_valid), 12'h0);
    check("rst pix_color", pix_color, 12'h000);
    check("rst commit_pending", 12'(commit_pending), 12'h0);

    // Single hit
    write_entry(0, 100, 100, 10, 12'hF00);
    pulse_commit();
    model_swap();
    add(100, 100, 1'b1, 12'hF00);
    add(110, 100, 1'b0, 12'hF00);
    add(111, 100, 1'b0, BG);
    add(100,  90, 1'b0, 12'hF00);
    add( 93,  93, 1'b0, 12'hF00);
    add( 92,  93, 1'b0, BG);
    run_table("single");

    // Priority and overlap
    write_entry(0, 0, 0, 5, 12'h0F0);
    write_entry(3, 0, 0, 50, 12'hFFF);
    pulse_commit();
    model_swap();
    add( 3,  0, 1'b1, 12'h0F0);
    add(30,  0, 1'b0, 12'hFFF);
    add( 5,  0, 1'b0, 12'h0F0);
    add( 6,  0, 1'b0, 12'hFFF);
    add( 0, -5, 1'b0, 12'h0F0);
    add(30, 40, 1'b0, 12'hFFF);
    add(30, 41, 1'b0, BG);
    add(51,  0, 1'b0, BG);
    run_table("prio");

    // Extremes, negative coordinates, disabled radii
    write_entry(0, -2048, -2048, 2047, 12'h0A5);
    write_entry(1, 500, 500, -5, 12'h777);
    write_entry(3, 0, 0, 0, 12'h123);
    pulse_commit();
    model_swap();
    add( 2047,  2047, 1'b1, BG);
    add(-2048,    -1, 1'b0, 12'h0A5);
    add(   -1, -2048, 1'b0, 12'h0A5);
    add(-2048,     0, 1'b0, BG);
    add(-2048, -2048, 1'b0, 12'h0A5);
    add( 2047, -2048, 1'b0, BG);
    add(    0,     0, 1'b0, BG);
    add(  500,   500, 1'b0, BG);
    run_table("extreme");

    // Commit timing
    write_entry(2, 0, 0, 100, 12'h0F0);
    apply_px(0, 0, 1'b0, 1'b0, BG, 1'b0, "ct_shadow_only");
    apply_px(0, 0, 1'b1, 1'b1, BG, 1'b1, "ct_commit_with_fs");
    apply_px(5, 0, 1'b0, 1'b1, BG, 1'b1, "ct_pending");
    set_wr(1, 10, 10, 3, 12'hF0F);
    model_swap();
    apply_px(0, 0, 1'b1, 1'b0, 12'h0F0, 1'b0, "ct_swap");
    apply_px(10, 10, 1'b0, 1'b0, 12'hF0F, 1'b0, "ct_swap_write");
    apply_px(0, 0, 1'b1, 1'b0, 12'h0F0, 1'b0, "ct_fs_idle");

    // Random stream with bubbles
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) q.push_back(13'h0);
    for (int c = 0; c < 1004; c++) begin
      e = q.pop_front();
      if (e[12]) begin
        check($sformatf("stream[%0d] valid", c), 12'(pix_valid), 12'h1);
        check($sformatf("stream[%0d] color", c), pix_color, e[11:0]);
        last_col = e[11:0];
      end else begin
        check($sformatf("stream[%0d] valid", c), 12'(pix_valid), 12'h0);
        check($sformatf("stream[%0d] hold", c), pix_color, last_col);
      end
      v = (c < 1000) && ($urandom_range(0, 2) != 0);
      x = rnd_coord();
      y = rnd_coord();
      px_valid = v; px_x = 12'(x); px_y = 12'(y);
      q.push_back({v, model(x, y)});
      @(negedge clk);
    end
    px_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset with pixels in flight and a commit pending
    pulse_commit();
    for (int k = 0; k < 3; k++) begin
      px_valid = 1'b1; px_x = 12'(-2048); px_y = 12'(-2048);
      @(negedge clk);
    end
    px_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    last_col = 12'h000;
    check("midrst pix_valid", 12'(pix_valid), 12'h0);
    check("midrst pix_color", pix_color, 12'h000);
    check("midrst commit_pending", 12'(commit_pending), 12'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst drop[%0d]", k), 12'(pix_valid), 12'h0);
    end
    apply_px(-2048, -2048, 1'b1, 1'b0, BG, 1'b0, "rst_disabled");
    apply_px(0, 0, 1'b0, 1'b0, BG, 1'b0, "rst_disabled2");
    write_entry(0, -2048, -2048, 2047, 12'h0A5);
    pulse_commit();
    apply_px(-2048, -2048, 1'b1, 1'b0, 12'h0A5, 1'b0, "rst_rewrite");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
